// File: rtl/paquete_botones.sv
// Shared types and helpers for the button event reader: direction codes,
// per-button arming state and the fixed-priority winner selection.
package paquete_botones;

    typedef enum logic [1:0] {ARRIBA, ABAJO, IZQUIERDA, DERECHA} direccion_t;

    typedef enum logic {DESARMADO, ARMADO} estado_boton_t;

    localparam int NUM_BOTONES = 4;

    // Lowest index wins: arriba > abajo > izquierda > derecha.
    function automatic direccion_t prioridad(input logic [NUM_BOTONES-1:0] pendientes);
        direccion_t ganador;
        ganador = ARRIBA;
        for (int i = NUM_BOTONES - 1; i >= 0; i--) begin
            if (pendientes[i]) begin
                ganador = direccion_t'(2'(i));
            end
        end
        return ganador;
    endfunction

endpackage

// File: rtl/filtro_antirrebote.sv
// One button lane: 2-FF synchronizer, debounce counter and arm/disarm FSM
// that emits a single-cycle evento when the debounced level rises while armed.
module filtro_antirrebote
    import paquete_botones::*;
#(
    parameter int CICLOS_ANTIRREBOTE = 16
)
(
    input  logic reloj,
    input  logic reinicio,
    input  logic bandera,
    output logic evento
);

    localparam int ANCHO_CUENTA = (CICLOS_ANTIRREBOTE > 1) ? $clog2(CICLOS_ANTIRREBOTE) : 1;
    localparam logic [ANCHO_CUENTA-1:0] CUENTA_FINAL = ANCHO_CUENTA'(CICLOS_ANTIRREBOTE - 1);

    logic                    sincA;
    logic                    sincB;
    logic                    estable;
    logic [ANCHO_CUENTA-1:0] cuenta;
    estado_boton_t           estado;
    logic                    cambioConfirmado;

    // The new level is committed on the edge where the count is already at its final value.
    assign cambioConfirmado = (sincB != estable) && (cuenta == CUENTA_FINAL);
    assign evento           = (estado == ARMADO) && cambioConfirmado && sincB;

    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            sincA   <= 1'b0;
            sincB   <= 1'b0;
            estable <= 1'b0;
            cuenta  <= '0;
            estado  <= DESARMADO;
        end else begin
            sincA <= bandera;
            sincB <= sincA;

            if (sincB == estable) begin
                cuenta <= '0;
            end else if (cambioConfirmado) begin
                estable <= sincB;
                cuenta  <= '0;
            end else begin
                cuenta <= cuenta + 1'b1;
            end

            if (estado == DESARMADO) begin
                if (!estable) begin
                    estado <= ARMADO;
                end
            end else if (evento) begin
                estado <= DESARMADO;
            end
        end
    end

endmodule

// File: rtl/lector_eventos_botones.sv
// Turns debounced button presses into single direction commands over a
// valid/ready handshake, pulsing a latch clear after every accepted command.
module lector_eventos_botones
    import paquete_botones::*;
#(
    parameter int CICLOS_ANTIRREBOTE = 16,
    parameter int ANCHO_CONTADOR     = 8
)
(
    input  logic                      reloj,
    input  logic                      reinicio,
    input  logic                      banderaArriba,
    input  logic                      banderaAbajo,
    input  logic                      banderaIzquierda,
    input  logic                      banderaDerecha,
    output logic                      comandoValido,
    input  logic                      comandoListo,
    output logic [1:0]                comandoDireccion,
    output logic                      solicitudLimpieza,
    output logic [ANCHO_CONTADOR-1:0] eventosPerdidos
);

    localparam int ANCHO_SUMA = ANCHO_CONTADOR + 3;
    localparam logic [ANCHO_SUMA-1:0] MAXIMO = {3'b000, {ANCHO_CONTADOR{1'b1}}};

    logic [NUM_BOTONES-1:0] banderas;
    logic [NUM_BOTONES-1:0] eventos;
    logic [NUM_BOTONES-1:0] pendientes;
    logic [NUM_BOTONES-1:0] limpiar;
    logic [NUM_BOTONES-1:0] fusionados;
    logic                   transferencia;
    direccion_t             ganador;
    logic [2:0]             numFusionados;
    logic [ANCHO_SUMA-1:0]  sumaPerdidos;

    assign banderas      = {banderaDerecha, banderaIzquierda, banderaAbajo, banderaArriba};
    assign transferencia = comandoValido && comandoListo;
    assign ganador       = prioridad(pendientes);

    generate
        for (genvar gi = 0; gi < NUM_BOTONES; gi++) begin : gen_boton
            filtro_antirrebote #(
                .CICLOS_ANTIRREBOTE(CICLOS_ANTIRREBOTE)
            ) uFiltro (
                .reloj   (reloj),
                .reinicio(reinicio),
                .bandera (banderas[gi]),
                .evento  (eventos[gi])
            );

            assign limpiar[gi] = transferencia && (comandoDireccion == 2'(gi));
            // A new press coinciding with its own clear re-queues rather than being lost.
            assign fusionados[gi] = eventos[gi] && pendientes[gi] && !limpiar[gi];
        end
    endgenerate

    always_comb begin
        numFusionados = '0;
        for (int i = 0; i < NUM_BOTONES; i++) begin
            numFusionados = numFusionados + 3'(fusionados[i]);
        end
    end

    assign sumaPerdidos = {3'b000, eventosPerdidos} + ANCHO_SUMA'(numFusionados);

    always_ff @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            comandoValido     <= 1'b0;
            comandoDireccion  <= 2'd0;
            solicitudLimpieza <= 1'b0;
            eventosPerdidos   <= '0;
            pendientes        <= '0;
        end else begin
            solicitudLimpieza <= transferencia;

            // The gap cycle after a transfer keeps the handshake at one command per two cycles.
            if (transferencia) begin
                comandoValido <= 1'b0;
            end else if (!comandoValido && (|pendientes)) begin
                comandoValido    <= 1'b1;
                comandoDireccion <= ganador;
            end

            pendientes <= eventos | (pendientes & ~limpiar);

            if (sumaPerdidos > MAXIMO) begin
                eventosPerdidos <= MAXIMO[ANCHO_CONTADOR-1:0];
            end else begin
                eventosPerdidos <= sumaPerdidos[ANCHO_CONTADOR-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lector_eventos_botones.sv
// Bench for lector_eventos_botones: table-driven sequences, directed corner
// cases and a randomized run against a behavioural model.
module tb_lector_eventos_botones;

    localparam int C = 4;

    logic       reloj = 1'b0;
    logic       reinicio;
    logic       arriba, abajo, izq, der;
    logic       listo;
    logic       valido;
    logic [1:0] dir;
    logic       limp;
    logic [7:0] perdidos;

    logic       satArriba;
    logic       satValido;
    logic [1:0] satDir;
    logic       satLimp;
    logic [1:0] satPerdidos;

    int compared   = 0;
    int mismatched = 0;
    int transfers  = 0;
    int cuentaValido = 0;

    always #5 reloj = ~reloj;

    lector_eventos_botones #(.CICLOS_ANTIRREBOTE(C), .ANCHO_CONTADOR(8)) dut (
        .reloj            (reloj),
        .reinicio         (reinicio),
        .banderaArriba    (arriba),
        .banderaAbajo     (abajo),
        .banderaIzquierda (izq),
        .banderaDerecha   (der),
        .comandoValido    (valido),
        .comandoListo     (listo),
        .comandoDireccion (dir),
        .solicitudLimpieza(limp),
        .eventosPerdidos  (perdidos)
    );

    lector_eventos_botones #(.CICLOS_ANTIRREBOTE(C), .ANCHO_CONTADOR(2)) dutSat (
        .reloj            (reloj),
        .reinicio         (reinicio),
        .banderaArriba    (satArriba),
        .banderaAbajo     (1'b0),
        .banderaIzquierda (1'b0),
        .banderaDerecha   (1'b0),
        .comandoValido    (satValido),
        .comandoListo     (1'b0),
        .comandoDireccion (satDir),
        .solicitudLimpieza(satLimp),
        .eventosPerdidos  (satPerdidos)
    );

    // Transaction monitor on the main instance.
    always @(posedge reloj) begin
        if (valido) cuentaValido++;
        if (valido && listo) begin
            transfers++;
            $display("cmd dir=%0d perdidos=%0d t=%0t", dir, perdidos, $time);
        end
    end

    // Behavioural model: debounced level = last C synchronized samples agree,
    // an event is a rise of that level, then pending set / arbitration / handshake.
    logic [3:0] mD1, mD2, mEstable, mPend, mEv;
    logic [3:0] mVent [4];
    logic       mValido, mLimp, mTrans, mClr;
    logic [1:0] mDir, mDirPrevio;
    int         mPerdidos;

    always @(posedge reloj or negedge reinicio) begin
        if (!reinicio) begin
            mD1 = '0; mD2 = '0; mEstable = '0; mPend = '0; mEv = '0;
            for (int i = 0; i < 4; i++) mVent[i] = '0;
            mValido = 1'b0; mLimp = 1'b0; mDir = 2'd0; mPerdidos = 0;
        end else begin
            mTrans = mValido && listo;
            mDirPrevio = mDir;
            mEv = '0;
            for (int i = 0; i < 4; i++) begin
                mVent[i] = {mVent[i][2:0], mD2[i]};
                if (mVent[i] == {4{~mEstable[i]}}) begin
                    mEstable[i] = ~mEstable[i];
                    mEv[i] = mEstable[i];
                end
            end
            mD2 = mD1;
            mD1 = {der, izq, abajo, arriba};
            mLimp = mTrans;
            if (mTrans) begin
                mValido = 1'b0;
            end else if (!mValido && mPend != 4'd0) begin
                for (int i = 3; i >= 0; i--) if (mPend[i]) mDir = 2'(i);
                mValido = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                mClr = mTrans && (mDirPrevio == 2'(i));
                if (mEv[i]) begin
                    if (mPend[i] && !mClr && mPerdidos < 255) mPerdidos++;
                    mPend[i] = 1'b1;
                end else if (mClr) begin
                    mPend[i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nombre, input int actual, input int esperado);
        compared++;
        if (actual != esperado) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nombre, actual, esperado, $time);
        end
    endtask

    task automatic ciclos(input int n);
        repeat (n) @(negedge reloj);
    endtask

    task automatic banderas(input logic [3:0] f);
        arriba = f[0]; abajo = f[1]; izq = f[2]; der = f[3];
    endtask

    typedef struct {
        int         ciclos;
        logic [3:0] flags;
        logic       listo;
        logic       valido;
        logic [1:0] dir;
        logic       limpieza;
        int         perdidos;
    } vector_t;

    vector_t tabla [13];
    int      t0, v0, malos;
    int      resto [4];
    logic [3:0] nivel;

    initial begin
        // Arriba held: command at cycle 7, clear pulse after transfer, no repeat.
        tabla[0]  = '{6,  4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 0};
        tabla[1]  = '{1,  4'b0001, 1'b1, 1'b1, 2'd0, 1'b0, 0};
        tabla[2]  = '{1,  4'b0001, 1'b1, 1'b0, 2'd0, 1'b1, 0};
        tabla[3]  = '{1,  4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 0};
        tabla[4]  = '{20, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 0};
        tabla[5]  = '{10, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 0};
        // Abajo and izquierda together: served in priority order.
        tabla[6]  = '{6,  4'b0110, 1'b1, 1'b0, 2'd0, 1'b0, 0};
        tabla[7]  = '{1,  4'b0110, 1'b1, 1'b1, 2'd1, 1'b0, 0};
        tabla[8]  = '{1,  4'b0110, 1'b1, 1'b0, 2'd1, 1'b1, 0};
        tabla[9]  = '{1,  4'b0110, 1'b1, 1'b1, 2'd2, 1'b0, 0};
        tabla[10] = '{1,  4'b0110, 1'b1, 1'b0, 2'd2, 1'b1, 0};
        tabla[11] = '{1,  4'b0110, 1'b1, 1'b0, 2'd2, 1'b0, 0};
        tabla[12] = '{10, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0, 0};

        reinicio = 1'b0;
        banderas(4'b0000);
        satArriba = 1'b0;
        listo = 1'b0;
        ciclos(3);
        chk("reset_valido", valido, 0);
        chk("reset_dir", dir, 0);
        chk("reset_limpieza", limp, 0);
        chk("reset_perdidos", perdidos, 0);
        reinicio = 1'b1;

        t0 = transfers;
        for (int k = 0; k < 13; k++) begin
            banderas(tabla[k].flags);
            listo = tabla[k].listo;
            ciclos(tabla[k].ciclos);
            chk($sformatf("tabla%0d_valido", k), valido, tabla[k].valido);
            chk($sformatf("tabla%0d_dir", k), dir, tabla[k].dir);
            chk($sformatf("tabla%0d_limpieza", k), limp, tabla[k].limpieza);
            chk($sformatf("tabla%0d_perdidos", k), perdidos, tabla[k].perdidos);
        end
        chk("tabla_transfers", transfers - t0, 3);

        // Glitch shorter than the debounce window.
        banderas(4'b1000);
        ciclos(3);
        banderas(4'b0000);
        v0 = cuentaValido;
        ciclos(20);
        chk("glitch_sin_comando", cuentaValido - v0, 0);
        chk("glitch_perdidos", perdidos, 0);

        // Backpressure: derecha held while arriba arrives.
        listo = 1'b0;
        banderas(4'b1000);
        ciclos(7);
        chk("bp_valido", valido, 1);
        chk("bp_dir", dir, 3);
        banderas(4'b1001);
        malos = 0;
        for (int k = 0; k < 12; k++) begin
            ciclos(1);
            if (!(valido && dir == 2'd3)) malos++;
        end
        chk("bp_estable", malos, 0);
        listo = 1'b1;
        ciclos(1);
        chk("bp_transfer_valido", valido, 0);
        chk("bp_transfer_limpieza", limp, 1);
        ciclos(1);
        chk("bp_arriba_valido", valido, 1);
        chk("bp_arriba_dir", dir, 0);
        ciclos(1);
        chk("bp_arriba_limpieza", limp, 1);
        banderas(4'b0000);
        ciclos(12);
        chk("bp_reposo", valido, 0);

        // Re-presses merged into a pending, unaccepted arriba.
        listo = 1'b0;
        banderas(4'b0001);
        ciclos(7);
        chk("merge_valido", valido, 1);
        chk("merge_dir", dir, 0);
        repeat (2) begin
            banderas(4'b0000); ciclos(10);
            banderas(4'b0001); ciclos(10);
        end
        chk("merge_perdidos", perdidos, 2);
        t0 = transfers;
        listo = 1'b1;
        ciclos(20);
        chk("merge_un_comando", transfers - t0, 1);
        banderas(4'b0000);
        ciclos(10);

        // Saturation on the 2-bit counter instance.
        satArriba = 1'b1;
        ciclos(10);
        for (int r = 1; r <= 5; r++) begin
            satArriba = 1'b0; ciclos(10);
            satArriba = 1'b1; ciclos(10);
            if (r == 2) chk("sat_dos", satPerdidos, 2);
        end
        chk("sat_tope", satPerdidos, 3);
        chk("sat_valido", satValido, 1);
        chk("sat_dir", satDir, 0);
        chk("sat_limpieza", satLimp, 0);
        satArriba = 1'b0;

        // Asynchronous reset with a command outstanding.
        listo = 1'b0;
        banderas(4'b1010);
        ciclos(7);
        chk("rst_pre_valido", valido, 1);
        chk("rst_pre_dir", dir, 1);
        #2 reinicio = 1'b0;
        #1;
        chk("rst_async_valido", valido, 0);
        chk("rst_async_dir", dir, 0);
        chk("rst_async_limpieza", limp, 0);
        chk("rst_async_perdidos", perdidos, 0);
        banderas(4'b0000);
        ciclos(3);
        reinicio = 1'b1;
        v0 = cuentaValido;
        ciclos(20);
        chk("rst_sin_residuo", cuentaValido - v0, 0);
        banderas(4'b0100);
        listo = 1'b1;
        ciclos(7);
        chk("rst_nuevo_valido", valido, 1);
        chk("rst_nuevo_dir", dir, 2);
        ciclos(1);
        chk("rst_nuevo_limpieza", limp, 1);
        banderas(4'b0000);
        ciclos(10);

        // Randomized traffic against the model.
        nivel = 4'b0000;
        for (int i = 0; i < 4; i++) resto[i] = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (resto[i] == 0) begin
                    nivel[i] = 1'($urandom_range(0, 1));
                    resto[i] = $urandom_range(1, 14);
                end
                resto[i]--;
            end
            banderas(nivel);
            listo = 1'($urandom_range(0, 1));
            ciclos(1);
            chk("rnd_valido", valido, mValido);
            chk("rnd_dir", dir, mDir);
            chk("rnd_limpieza", limp, mLimp);
            chk("rnd_perdidos", perdidos, mPerdidos);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
